// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester arbiter owning an 8 x 8-bit memory.
// Requesters A and B each present req/wen/addr/w_data. One request is accepted
// per IDLE cycle; the following cycle is a SERVE cycle that pulses gnt_x (and
// rvalid_x for reads), with r_data_x holding the last read result.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   req_x, wen_x              access request, 1 = write / 0 = read
//   addr_x[2:0], w_data_x[7:0] word address and write data
//   gnt_x, rvalid_x           one-cycle grant / read-valid pulses
//   r_data_x[7:0]             read data, held until the next read by x
//   busy                      high in either SERVE state
// Build option: define MEM_ARBITER_FIXED_PRIO_EN to give A fixed priority
// instead of round-robin arbitration.
module mem_arbiter (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_a,
    input  logic       wen_a,
    input  logic [2:0] addr_a,
    input  logic [7:0] w_data_a,
    output logic       gnt_a,
    output logic [7:0] r_data_a,
    output logic       rvalid_a,
    input  logic       req_b,
    input  logic       wen_b,
    input  logic [2:0] addr_b,
    input  logic [7:0] w_data_b,
    output logic       gnt_b,
    output logic [7:0] r_data_b,
    output logic       rvalid_b,
    output logic       busy
);
    typedef enum logic [1:0] {IDLE, SERVE_A, SERVE_B} state_t;
    state_t     state;
    logic [7:0] mem [8];
    logic       pick_a;
    logic       pick_b;
`ifdef MEM_ARBITER_FIXED_PRIO_EN
    assign pick_a = req_a;
`else
    // last_b = 1 means B was served most recently, so A wins a tie
    logic last_b;
    assign pick_a = req_a && (!req_b || last_b);
`endif
    assign pick_b = req_b && !pick_a;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            gnt_a    <= 1'b0;
            gnt_b    <= 1'b0;
            rvalid_a <= 1'b0;
            rvalid_b <= 1'b0;
            busy     <= 1'b0;
            r_data_a <= 8'h00;
            r_data_b <= 8'h00;
            for (int i = 0; i < 8; i++) mem[i] <= 8'h00;
`ifndef MEM_ARBITER_FIXED_PRIO_EN
            last_b   <= 1'b1;
`endif
        end else begin
            // SERVE always falls back to IDLE; pulses default low
            state    <= IDLE;
            gnt_a    <= 1'b0;
            gnt_b    <= 1'b0;
            rvalid_a <= 1'b0;
            rvalid_b <= 1'b0;
            busy     <= 1'b0;
            if (state == IDLE && pick_a) begin
                state    <= SERVE_A;
                gnt_a    <= 1'b1;
                busy     <= 1'b1;
                rvalid_a <= !wen_a;
                if (wen_a) mem[addr_a] <= w_data_a;
                else r_data_a <= mem[addr_a];
`ifndef MEM_ARBITER_FIXED_PRIO_EN
                last_b   <= 1'b0;
`endif
            end else if (state == IDLE && pick_b) begin
                state    <= SERVE_B;
                gnt_b    <= 1'b1;
                busy     <= 1'b1;
                rvalid_b <= !wen_b;
                if (wen_b) mem[addr_b] <= w_data_b;
                else r_data_b <= mem[addr_b];
`ifndef MEM_ARBITER_FIXED_PRIO_EN
                last_b   <= 1'b1;
`endif
            end
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus randomized traffic against a
// transaction-level reference model of the arbiter and its memory.
module tb_mem_arbiter;
    logic       clk = 1'b0;
    logic       rst, req_a, wen_a, req_b, wen_b;
    logic [2:0] addr_a, addr_b;
    logic [7:0] w_data_a, w_data_b;
    logic       gnt_a, gnt_b, rvalid_a, rvalid_b, busy;
    logic [7:0] r_data_a, r_data_b;

    mem_arbiter dut (
        .clk(clk), .rst(rst),
        .req_a(req_a), .wen_a(wen_a), .addr_a(addr_a), .w_data_a(w_data_a),
        .gnt_a(gnt_a), .r_data_a(r_data_a), .rvalid_a(rvalid_a),
        .req_b(req_b), .wen_b(wen_b), .addr_b(addr_b), .w_data_b(w_data_b),
        .gnt_b(gnt_b), .r_data_b(r_data_b), .rvalid_b(rvalid_b),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference model: memory image, whether a grant is in flight, who went last
    logic [7:0] m_mem [8];
    bit         m_inflight;
    bit         m_b_last;
    bit         e_gnt_a, e_gnt_b, e_rv_a, e_rv_b;
    logic [7:0] e_rd_a, e_rd_b;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic model_edge();
        bit a_win, b_win;
        e_gnt_a = 0; e_gnt_b = 0; e_rv_a = 0; e_rv_b = 0;
        if (rst) begin
            foreach (m_mem[i]) m_mem[i] = 8'h00;
            e_rd_a = 0; e_rd_b = 0; m_inflight = 0; m_b_last = 1;
        end else if (m_inflight) begin
            m_inflight = 0;
        end else begin
`ifdef MEM_ARBITER_FIXED_PRIO_EN
            a_win = req_a;
`else
            a_win = req_a && (!req_b || m_b_last);
`endif
            b_win = req_b && !a_win;
            if (a_win) begin
                if (wen_a) m_mem[addr_a] = w_data_a; else e_rd_a = m_mem[addr_a];
                e_gnt_a = 1; e_rv_a = !wen_a; m_b_last = 0;
            end
            if (b_win) begin
                if (wen_b) m_mem[addr_b] = w_data_b; else e_rd_b = m_mem[addr_b];
                e_gnt_b = 1; e_rv_b = !wen_b; m_b_last = 1;
            end
            m_inflight = a_win || b_win;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("gnt_a", gnt_a, e_gnt_a);
        check("gnt_b", gnt_b, e_gnt_b);
        check("rvalid_a", rvalid_a, e_rv_a);
        check("rvalid_b", rvalid_b, e_rv_b);
        check("r_data_a", r_data_a, e_rd_a);
        check("r_data_b", r_data_b, e_rd_b);
        check("busy", busy, m_inflight);
    endtask

    task automatic cmd_a(input bit r, input bit w, input logic [2:0] a, input logic [7:0] d);
        req_a = r; wen_a = w; addr_a = a; w_data_a = d;
    endtask

    task automatic cmd_b(input bit r, input bit w, input logic [2:0] a, input logic [7:0] d);
        req_b = r; wen_b = w; addr_b = a; w_data_b = d;
    endtask

    initial begin
        int n_gnt, n_rv;
        rst = 1;
        cmd_a(0, 0, 0, 0);
        cmd_b(0, 0, 0, 0);
        step();
        step();
        rst = 0;
        check("rst_busy", busy, 0);
        check("rst_rdata_a", r_data_a, 0);

        // A reads addr 5 right after reset
        cmd_a(1, 0, 5, 0);
        step();
        check("r21_gnt", gnt_a, 1);
        check("r21_rvalid", rvalid_a, 1);
        check("r21_data", r_data_a, 8'h00);
        cmd_a(0, 0, 0, 0);
        step();

        // A writes A5 @3, then B reads it back
        cmd_a(1, 1, 3, 8'hA5);
        step();
        check("r22_gnt_a", gnt_a, 1);
        check("r22_rvalid_a", rvalid_a, 0);
        cmd_a(0, 0, 0, 0);
        cmd_b(1, 0, 3, 0);
        step();
        check("r22_idle_busy", busy, 0);
        step();
        check("r22_gnt_b", gnt_b, 1);
        check("r22_data_b", r_data_b, 8'hA5);
        cmd_b(0, 0, 0, 0);
        step();

        // both requesters hold writes to @1 straight out of reset
        rst = 1;
        cmd_a(1, 1, 1, 8'h11);
        cmd_b(1, 1, 1, 8'h22);
        step();
        rst = 0;
        for (int k = 0; k < 8; k++) begin
            step();
`ifdef MEM_ARBITER_FIXED_PRIO_EN
            check("r25_gnt_a", gnt_a, k % 2 == 0);
            check("r25_gnt_b", gnt_b, 0);
`else
            check("r23_gnt_a", gnt_a, k % 4 == 0);
            check("r23_gnt_b", gnt_b, k % 4 == 2);
`endif
        end
`ifdef MEM_ARBITER_FIXED_PRIO_EN
        cmd_a(0, 0, 0, 0);
        step();
        check("r25_b_after_a_drops", gnt_b, 1);
        cmd_b(0, 0, 0, 0);
        step();
        cmd_a(1, 0, 1, 0);
        step();
        check("r25_read_gnt", gnt_a, 1);
        check("r25_read_data", r_data_a, 8'h22);
`else
        cmd_b(0, 0, 0, 0);
        cmd_a(1, 0, 1, 0);
        step();
        check("r23_read_gnt", gnt_a, 1);
        check("r23_read_data", r_data_a, 8'h22);
`endif
        cmd_a(0, 0, 0, 0);
        step();

        // reset lands on the edge that would accept a write of 7E @6
        cmd_a(1, 1, 6, 8'h55);
        step();
        cmd_a(0, 0, 0, 0);
        step();
        cmd_a(1, 1, 6, 8'h7E);
        rst = 1;
        step();
        check("r24_gnt", gnt_a, 0);
        check("r24_busy", busy, 0);
        rst = 0;
        cmd_a(1, 0, 6, 0);
        step();
        check("r24_read_gnt", gnt_a, 1);
        check("r24_read_data", r_data_a, 8'h00);
        cmd_a(0, 0, 0, 0);
        step();

        // A holds a read @2 through its gnt cycle, then drops
        n_gnt = 0;
        n_rv = 0;
        cmd_a(1, 0, 2, 0);
        for (int k = 0; k < 4; k++) begin
            if (k == 2) cmd_a(0, 0, 0, 0);
            step();
            n_gnt += int'(gnt_a);
            n_rv += int'(rvalid_a);
        end
        check("r26_gnt_count", n_gnt, 1);
        check("r26_rvalid_count", n_rv, 1);

        // randomized traffic: a pending request is held until granted
        for (int c = 0; c < 3000; c++) begin
            bit ga, gb;
            ga = gnt_a;
            gb = gnt_b;
            rst = ($urandom_range(0, 63) == 0);
            if (!req_a || ga)
                cmd_a($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                      3'($urandom_range(0, 7)), 8'($urandom));
            if (!req_b || gb)
                cmd_b($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                      3'($urandom_range(0, 7)), 8'($urandom));
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
